// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared encodings and constants for the EX-stage divider
package div_ctrl_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [DIV_DATA_W-1:0] ZeroWord = '0;

    typedef logic [2*DIV_DATA_W-1:0] double_reg_bus_t;

    // aluop codes EX decodes to raise start_i / signed_div_i
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

endpackage

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - EX <-> divider request/result interface
interface div_ctrl_if #(
    parameter int DATA_W = div_ctrl_pkg::DIV_DATA_W
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    // EX side: issues the request and consumes the result
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    // divider side
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift/trial-subtract iteration
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);
    logic [W:0]   shifted;
    logic [W-1:0] diff;

    // When the trial subtraction succeeds the true difference is below 2^W,
    // so the low W bits of the wrapped difference are exact.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted[W-1:0] - divisor;
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff : shifted[W-1:0];
    end
endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle DIV/DIVU sequencer (optional DIV_EARLY_OUT_EN)
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    div_ctrl_if.slave      bus
);
    div_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvd_q;     // dividend bits shift out at the top, quotient bits shift in at the bottom
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvs;
    logic              neg1, neg2;

    logic [DATA_W-1:0] mag1, mag2;
    logic [DATA_W-1:0] rem_nxt;
    logic              q_bit;
    logic              last_iter;
    logic              early;
    logic              accept;
    logic [DATA_W-1:0] quot_final, quot_fix, rem_fix;

    assign mag1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign mag2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

    assign accept    = bus.start_i && !bus.annul_i;
    assign last_iter = (cnt == CNT_W'(DATA_W - 1));

`ifdef DIV_EARLY_OUT_EN
    // Dividend smaller than divisor: quotient is zero, remainder is the dividend itself.
    assign early = (mag1 < mag2);
`else
    assign early = 1'b0;
`endif

    div_step #(.W(DATA_W)) u_step (
        .rem_in  (rem),
        .bit_in  (dvd_q[DATA_W-1]),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // Sign fix-up on the final iteration's outputs so the result registers on the same edge.
    assign quot_final = {dvd_q[DATA_W-2:0], q_bit};
    assign quot_fix   = (neg1 ^ neg2) ? -quot_final : quot_final;
    assign rem_fix    = neg1 ? -rem_nxt : rem_nxt;

    assign bus.busy_o = (state != DIV_FREE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= DIV_FREE;
        else     state <= state_nxt;
    end

    // Next-state logic; annul overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_FREE: begin
                if (accept) begin
                    if (bus.opdata2_i == ZeroWord) state_nxt = DIV_BY_ZERO;
                    else if (early)                state_nxt = DIV_END;
                    else                           state_nxt = DIV_ON;
                end
            end
            DIV_BY_ZERO: state_nxt = DIV_END;
            DIV_ON:      if (last_iter) state_nxt = DIV_END;
            DIV_END:     if (!bus.start_i) state_nxt = DIV_FREE;
            default:     state_nxt = DIV_FREE;
        endcase
        if (bus.annul_i) state_nxt = DIV_FREE;
    end

    // Datapath and registered result/ready
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            dvd_q        <= '0;
            rem          <= '0;
            dvs          <= '0;
            neg1         <= 1'b0;
            neg2         <= 1'b0;
            bus.result_o <= '0;
            bus.ready_o  <= DivResultNotReady;
        end else if (bus.annul_i) begin
            bus.result_o <= '0;
            bus.ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (bus.start_i) begin
                        dvd_q <= mag1;
                        dvs   <= mag2;
                        rem   <= '0;
                        cnt   <= '0;
                        neg1  <= bus.signed_div_i && bus.opdata1_i[DATA_W-1];
                        neg2  <= bus.signed_div_i && bus.opdata2_i[DATA_W-1];
                        if (bus.opdata2_i != ZeroWord && early) begin
                            bus.result_o <= {bus.opdata1_i, ZeroWord};
                            bus.ready_o  <= DivResultReady;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    bus.result_o <= '0;
                    bus.ready_o  <= DivResultReady;
                end
                DIV_ON: begin
                    dvd_q <= quot_final;
                    rem   <= rem_nxt;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        bus.result_o <= {rem_fix, quot_fix};
                        bus.ready_o  <= DivResultReady;
                    end
                end
                DIV_END: begin
                    if (!bus.start_i) begin
                        bus.result_o <= '0;
                        bus.ready_o  <= DivResultNotReady;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    always #5 clk = ~clk;

    div_ctrl_if #(.DATA_W(32)) bus ();

    div_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
    endtask

    // lat = cycle in which ready_o is first seen high (cycle 0 = start sampled)
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        issue(s, a, b);
        step();
        if (lat > 1) begin
            repeat (lat - 2) step();
            chk({tag, "_ready_early"}, {63'd0, bus.ready_o}, 64'd0);
            step();
        end
        chk({tag, "_ready"}, {63'd0, bus.ready_o}, 64'd1);
        chk({tag, "_result"}, bus.result_o, exp);
        step();
        chk({tag, "_hold"}, {63'd0, bus.ready_o}, 64'd1);
        bus.start_i = 1'b0;
        step();
        chk({tag, "_drop_ready"}, {63'd0, bus.ready_o}, 64'd0);
        chk({tag, "_drop_busy"}, {63'd0, bus.busy_o}, 64'd0);
        chk({tag, "_drop_result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        step();
        step();
        chk("rst_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("rst_result", bus.result_o, 64'd0);
        rst = 1'b0;
        step();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
        run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);

        // divide by zero passes through DIV_BY_ZERO
        issue(1'b0, 32'h1234, 32'd0);
        step();
        chk("dbz_state", {62'd0, dut.state}, {62'd0, DIV_BY_ZERO});
        chk("dbz_ready_c1", {63'd0, bus.ready_o}, 64'd0);
        step();
        chk("dbz_ready_c2", {63'd0, bus.ready_o}, 64'd1);
        chk("dbz_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        step();
        chk("dbz_free", {63'd0, bus.busy_o}, 64'd0);

        // annul at cycle 10, then restart
        issue(1'b0, 32'd1000, 32'd3);
        step();
        for (int i = 1; i < 10; i++) begin
            chk("annul_no_ready", {63'd0, bus.ready_o}, 64'd0);
            step();
        end
        bus.annul_i = 1'b1;
        step();
        chk("annul_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("annul_ready", {63'd0, bus.ready_o}, 64'd0);
        bus.annul_i = 1'b0;
        run_div("restart_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        // start together with annul is ignored
        issue(1'b0, 32'd50, 32'd5);
        bus.annul_i = 1'b1;
        step();
        chk("start_annul_busy", {63'd0, bus.busy_o}, 64'd0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        step();

        // synchronous reset in the middle of a divide
        issue(1'b0, 32'd1000, 32'd3);
        step();
        repeat (14) step();
        chk("mid_busy", {63'd0, bus.busy_o}, 64'd1);
        rst = 1'b1;
        step();
        chk("mrst_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("mrst_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("mrst_result", bus.result_o, 64'd0);
        rst = 1'b0;
        run_div("post_rst_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        // small dividend: early-out latency when enabled, identical result either way
        run_div("divu_5_9", 1'b0, 32'd5, 32'd9, 64'h00000005_00000000, EARLY_LAT);
        run_div("div_m5_9", 1'b1, 32'hFFFFFFFB, 32'd9, 64'hFFFFFFFB_00000000, EARLY_LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer and datapath for multi-cycle DIV/DIVU in the EX stage: 32-iteration restoring (shift-subtract) divider under an FSM.
- EX issues a start request with operands and holds its `stallreq` high until `ready_o` returns.
- Result `{remainder, quotient}` is handed back to EX for the HI/LO write.
- `annul_i` lets the pipeline kill an in-flight divide on flush, e.g. a divide sitting in a branch delay slot.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request; held high by EX until ready_o seen.
- annul_i  in  1  abort current/pending divide.
- result_o  out  2*DATA_W  {remainder, quotient}.
- ready_o  out  1  result valid.
- busy_o  out  1  FSM not in DIV_FREE.

Behaviour:
- Reset:
  - state = DIV_FREE, counter = 0.
  - result_o = 0, ready_o = 0, busy_o = 0.
  - Reset mid-operation discards all work.
- Outputs: result_o and ready_o are registered. busy_o = (state != DIV_FREE).
- States are DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END. Cycle 0 is the first cycle start_i is sampled high in DIV_FREE.
- DIV_FREE:
  - On start_i & !annul_i: latch operands. If signed_div_i and an operand is negative, store its two's-complement magnitude; also latch the two sign bits.
  - If divisor == 0, go to DIV_BY_ZERO; otherwise go to DIV_ON with counter = 0.
  - start_i & annul_i in the same cycle: ignored, stay in FREE.
- DIV_ON:
  - Per cycle: take the partial remainder shifted left 1 with the next dividend bit, then trial-subtract the divisor magnitude.
  - Non-negative difference: keep it and shift in quotient bit 1. Otherwise keep the shifted value and shift in 0.
  - counter increments each cycle. When counter reaches DATA_W, go to DIV_END (32 iteration cycles, cycles 1..32).
- DIV_END:
  - On entry: result_o = {rem, quot} with sign fix-up.
    - Quotient is negated iff signed and the operand signs differ.
    - Remainder is negated iff signed and the dividend is negative.
  - ready_o = 1 from cycle 33.
  - Stays in DIV_END while start_i = 1. On start_i = 0, go to DIV_FREE, ready_o = 0, result_o = 0.
- DIV_BY_ZERO: one cycle, then DIV_END with result_o = 0; ready_o = 1 at cycle 2.
- annul_i = 1 in DIV_ON, DIV_BY_ZERO or DIV_END: next state DIV_FREE, ready_o = 0, result_o = 0, no result delivered. annul_i has priority over every other transition.
- start_i dropped mid-DIV_ON without annul: the divide still completes. It then waits in DIV_END until start_i is low, which it already is, and returns to FREE one cycle later.
- Back-to-back divides: a new start is accepted only in DIV_FREE, i.e. at least one cycle after ready_o falls.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): magnitude arithmetic wraps; quotient = 0x80000000, remainder = 0. No exception.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in DIV_FREE, if divisor != 0 and |dividend| < |divisor| (unsigned magnitude compare), go directly to DIV_END.
  - Quotient = 0; remainder = the original dividend with its sign preserved.
  - ready_o = 1 at cycle 1.
- Undefined: all non-zero-divisor cases take the full 32 iterations (ready at cycle 33).
- Results are bit-identical either way; only latency differs.

Decomposition:
- Shared defines header holds the state encodings (DivFree, DivByZero, DivOn, DivEnd; 2 bits) plus DivResultReady/DivResultNotReady, DivStart/DivStop, ZeroWord and DoubleRegBus.
- The header also holds the EXE_DIV_OP/EXE_DIVU_OP aluop codes used by EX to drive start_i and signed_div_i.
- One natural sub-module: div_step, a combinational single-iteration shift/trial-subtract. It takes the partial remainder, the next dividend bit and the divisor, and returns the new remainder and quotient bit. It is instantiated once.

Test Plan:
- DIVU 100 / 7, start held: ready_o rises at cycle 33; result_o = 64'h00000002_0000000E. Drop start: ready_o = 0 next cycle, busy_o = 0.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002): result_o = 64'hFFFFFFFF_FFFFFFFD at cycle 33. Also DIV 7 / -2 gives 64'h00000001_FFFFFFFD.
- DIVU 0x1234 / 0: state passes through DIV_BY_ZERO; ready_o = 1 at cycle 2; result_o = 0.
- Annul: start DIVU 1000 / 3, assert annul_i at cycle 10.
  - FSM is back in FREE at cycle 11 and ready_o never rises.
  - Restart DIVU 9 / 3: result 64'h00000000_00000003 at 33 cycles after the restart.
- Reset at cycle 15 of a divide: all outputs 0 the cycle after reset; a new start is accepted immediately after reset deasserts.
- DIVU 5 / 9: with DIV_EARLY_OUT_EN, ready_o = 1 at cycle 1, result_o = 64'h00000005_00000000. Without the macro, the same result at cycle 33.
